// File: rtl/crc6_frame_checker.sv
// crc6_frame_checker: per-frame CRC-6 check over a valid/ready byte stream,
// with a consecutive-failure alarm and optional frame statistics.
// Optional feature macro: CRC_CHK_STATS_EN enables the stat_ok/stat_bad counters.
module crc6_frame_checker #(
  parameter int MAX_LEN      = 16,
  parameter int ALARM_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_ok,
  output logic        out_len_err,
  output logic        alarm,
  input  logic        alarm_clr,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_bad
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    DROP,
    CHECK,
    REPORT
  } state_t;

  localparam logic [5:0] CRC_INIT  = 6'h37;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [3:0] THRESH_B  = 4'(ALARM_THRESH);
  localparam logic       THRESH_IS_ONE = (ALARM_THRESH == 1);

  state_t      state;
  state_t      state_next;
  logic [5:0]  crc;
  logic [5:0]  crc_base;
  logic [5:0]  crc_upd;
  logic [7:0]  crc_rx;
  logic [7:0]  len;
  logic        len_err;
  logic [3:0]  fail_cnt;
  logic [3:0]  fail_inc;
  logic        accept;
  logic        ok_now;
  logic        check_good;
  logic        check_bad;
  logic        report_done;

  // One byte of the CRC-6 update, eight data bits folded in per call.
  function automatic logic [5:0] crc6_step(input logic [5:0] c, input logic [7:0] d);
    logic [5:0] n;
    n[0] = d[5] ^ d[2] ^ d[1] ^ d[0] ^ c[0] ^ c[3];
    n[1] = d[6] ^ d[5] ^ d[3] ^ d[0] ^ c[1] ^ c[3] ^ c[4];
    n[2] = d[7] ^ d[6] ^ d[5] ^ d[4] ^ d[2] ^ d[0] ^ c[0] ^ c[2] ^ c[3] ^ c[4] ^ c[5];
    n[3] = d[7] ^ d[6] ^ d[3] ^ d[2] ^ d[0] ^ c[0] ^ c[1] ^ c[4] ^ c[5];
    n[4] = d[7] ^ d[4] ^ d[3] ^ d[1] ^ c[1] ^ c[2] ^ c[5];
    n[5] = d[4] ^ d[1] ^ d[0] ^ c[2];
    return n;
  endfunction

  // The first byte of a frame is accepted in IDLE, before the register has
  // been reloaded, so the update starts from the seed constant there.
  assign crc_base    = (state == IDLE) ? CRC_INIT : crc;
  assign crc_upd     = crc6_step(crc_base, in_data);
  assign accept      = in_valid && in_ready;
  assign ok_now      = !len_err && (crc_rx[7:6] == 2'b00) && (crc_rx[5:0] == crc);
  assign check_good  = (state == CHECK) && ok_now;
  assign check_bad   = (state == CHECK) && !ok_now;
  assign report_done = (state == REPORT) && out_ready;
  assign fail_inc    = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: frame start, payload, overflow drop, check, report.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = in_last ? CHECK : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          if (in_last) begin
            state_next = CHECK;
          end else if (len == MAX_LEN_B) begin
            state_next = DROP;
          end
        end
      end
      DROP: begin
        if (accept && in_last) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        state_next = REPORT;
      end
      REPORT: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Input handshake is open only while collecting a frame, never during reset.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && (state == IDLE || state == DATA || state == DROP)) begin
      in_ready = 1'b1;
    end
  end

  // Frame datapath: CRC accumulation, length tracking and the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc         <= CRC_INIT;
      len         <= 8'd0;
      len_err     <= 1'b0;
      crc_rx      <= 8'd0;
      out_valid   <= 1'b0;
      out_ok      <= 1'b0;
      out_len_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          len_err <= 1'b0;
          if (accept && !in_last) begin
            crc <= crc_upd;
            len <= 8'd1;
          end else begin
            crc <= CRC_INIT;
            len <= 8'd0;
          end
          if (accept && in_last) begin
            crc_rx <= in_data;
          end
        end
        DATA: begin
          if (accept) begin
            if (in_last) begin
              crc_rx <= in_data;
            end else if (len == MAX_LEN_B) begin
              len_err <= 1'b1;
            end else begin
              crc <= crc_upd;
              len <= len + 8'd1;
            end
          end
        end
        DROP: begin
          if (accept && in_last) begin
            crc_rx <= in_data;
          end
        end
        CHECK: begin
          out_ok      <= ok_now;
          out_len_err <= len_err;
          out_valid   <= 1'b1;
        end
        REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Consecutive-failure counter and sticky alarm; a bad result arriving with
  // alarm_clr restarts the count at one instead of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt <= 4'd0;
      alarm    <= 1'b0;
    end else if (check_bad) begin
      if (alarm_clr) begin
        fail_cnt <= 4'd1;
        alarm    <= THRESH_IS_ONE;
      end else begin
        fail_cnt <= fail_inc;
        if (fail_inc >= THRESH_B) begin
          alarm <= 1'b1;
        end
      end
    end else if (alarm_clr) begin
      fail_cnt <= 4'd0;
      alarm    <= 1'b0;
    end else if (check_good) begin
      fail_cnt <= 4'd0;
    end
  end

`ifdef CRC_CHK_STATS_EN
  // Saturating good/bad frame counters, bumped when the consumer takes a result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ok  <= 16'h0000;
      stat_bad <= 16'h0000;
    end else if (report_done) begin
      if (out_ok) begin
        if (stat_ok != 16'hFFFF) begin
          stat_ok <= stat_ok + 16'd1;
        end
      end else begin
        if (stat_bad != 16'hFFFF) begin
          stat_bad <= stat_bad + 16'd1;
        end
      end
    end
  end
`else
  logic unused_report_done;
  assign unused_report_done = report_done;
  assign stat_ok  = 16'h0000;
  assign stat_bad = 16'h0000;
`endif

endmodule

// File: tb/tb_crc6_frame_checker.sv
// tb_crc6_frame_checker: directed scoreboard bench for crc6_frame_checker.
// Honours CRC_CHK_STATS_EN to decide what the statistics outputs should read.
module tb_crc6_frame_checker;

  localparam int MAX_LEN      = 16;
  localparam int ALARM_THRESH = 3;
`ifdef CRC_CHK_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic        out_ok;
  logic        out_len_err;
  logic        alarm;
  logic        alarm_clr;
  logic [15:0] stat_ok;
  logic [15:0] stat_bad;

  typedef struct packed {
    logic ok;
    logic lenErr;
    logic alarm;
    logic clr;
  } expect_t;

  expect_t     sb[$];
  int          total = 0;
  int          bad = 0;
  int          failCnt = 0;
  logic        alarmExp = 1'b0;
  logic [15:0] goodFrames = 16'd0;
  logic [15:0] badFrames = 16'd0;

  crc6_frame_checker #(
    .MAX_LEN(MAX_LEN),
    .ALARM_THRESH(ALARM_THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ok(out_ok),
    .out_len_err(out_len_err),
    .alarm(alarm),
    .alarm_clr(alarm_clr),
    .stat_ok(stat_ok),
    .stat_bad(stat_bad)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference CRC-6 byte step built from per-bit tap masks.
  function automatic logic [5:0] crcModel(input logic [5:0] c, input logic [7:0] d);
    logic [7:0] dMask [0:5];
    logic [5:0] cMask [0:5];
    logic [5:0] n;
    dMask = '{8'h27, 8'h69, 8'hF5, 8'hCD, 8'h9A, 8'h13};
    cMask = '{6'h09, 6'h1A, 6'h3D, 6'h33, 6'h26, 6'h04};
    for (int k = 0; k < 6; k++) begin
      n[k] = (^(d & dMask[k])) ^ (^(c & cMask[k]));
    end
    return n;
  endfunction

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkStats();
    checkWord("stat_ok", stat_ok, STATS_ON ? goodFrames : 16'h0000);
    checkWord("stat_bad", stat_bad, STATS_ON ? badFrames : 16'h0000);
  endtask

  // Present one beat and hold it until the DUT takes it on a rising edge.
  task automatic sendBeat(input logic [7:0] d, input logic l);
    int waitCount;
    waitCount = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && waitCount < 50) begin
      @(negedge clk);
      waitCount++;
    end
    if (!in_ready) begin
      checkBit("beat_accept_timeout", in_ready, 1'b1);
    end
    @(posedge clk);
  endtask

  // Drive a whole frame and push the expected result onto the scoreboard.
  // beatMode: 0 = beatRaw as given, 1 = correct CRC, 2 = correct CRC with bit 6 set.
  task automatic applyStimulus(input int len, input logic [7:0] seed, input int beatMode,
                               input logic [7:0] beatRaw, input logic clr);
    logic [5:0] c;
    logic [7:0] d;
    logic [7:0] beat;
    expect_t    e;
    c = 6'h37;
    for (int i = 0; i < len; i++) begin
      d = seed + 8'(i * 29);
      if (i < MAX_LEN) c = crcModel(c, d);
      sendBeat(d, 1'b0);
    end
    case (beatMode)
      1:       beat = {2'b00, c};
      2:       beat = {2'b01, c};
      default: beat = beatRaw;
    endcase
    sendBeat(beat, 1'b1);
    e.lenErr = (len > MAX_LEN);
    e.ok     = !e.lenErr && (beat[7:6] == 2'b00) && (beat[5:0] == c);
    e.clr    = clr;
    if (e.ok) begin
      failCnt = 0;
      if (clr) alarmExp = 1'b0;
    end else if (clr) begin
      failCnt  = 1;
      alarmExp = (ALARM_THRESH == 1);
    end else begin
      if (failCnt < 15) failCnt++;
      if (failCnt >= ALARM_THRESH) alarmExp = 1'b1;
    end
    e.alarm = alarmExp;
    sb.push_back(e);
  endtask

  // Follow the result through CHECK and REPORT, optionally stalling the consumer.
  task automatic checkOutput(input int holdCycles);
    expect_t e;
    if (sb.size() == 0) begin
      checkBit("scoreboard_empty", 1'b0, 1'b1);
      return;
    end
    e = sb.pop_front();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    if (e.clr) alarm_clr = 1'b1;
    checkBit("check_cycle_out_valid", out_valid, 1'b0);
    checkBit("check_cycle_in_ready", in_ready, 1'b0);
    @(negedge clk);
    alarm_clr = 1'b0;
    checkBit("out_valid", out_valid, 1'b1);
    checkBit("out_ok", out_ok, e.ok);
    checkBit("out_len_err", out_len_err, e.lenErr);
    checkBit("alarm", alarm, e.alarm);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkBit("hold_out_valid", out_valid, 1'b1);
      checkBit("hold_out_ok", out_ok, e.ok);
      checkBit("hold_out_len_err", out_len_err, e.lenErr);
      checkBit("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    if (e.ok) goodFrames++;
    else badFrames++;
    @(negedge clk);
    out_ready = 1'b0;
    checkBit("released_out_valid", out_valid, 1'b0);
    checkBit("released_in_ready", in_ready, 1'b1);
    checkStats();
  endtask

  task automatic clearAlarm();
    @(negedge clk);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    failCnt  = 0;
    alarmExp = 1'b0;
    checkBit("alarm_after_clear", alarm, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, "_in_ready"}, in_ready, 1'b0);
    checkBit({tag, "_out_valid"}, out_valid, 1'b0);
    checkBit({tag, "_out_ok"}, out_ok, 1'b0);
    checkBit({tag, "_out_len_err"}, out_len_err, 1'b0);
    checkBit({tag, "_alarm"}, alarm, 1'b0);
    checkWord({tag, "_stat_ok"}, stat_ok, 16'h0000);
    checkWord({tag, "_stat_bad"}, stat_bad, 16'h0000);
  endtask

  // Directed sequence covering the main check path, overflow, alarm and reset.
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    alarm_clr = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    #1;
    checkBit("in_ready_after_reset", in_ready, 1'b1);

    $display("[TB] single zero byte with correct CRC 0x31");
    applyStimulus(1, 8'h00, 0, 8'h31, 1'b0);
    checkOutput(0);

    $display("[TB] zero-payload frames");
    applyStimulus(0, 8'h00, 0, 8'h37, 1'b0);
    checkOutput(0);
    applyStimulus(0, 8'h00, 0, 8'h36, 1'b0);
    checkOutput(0);

    $display("[TB] length overflow and exact maximum length");
    applyStimulus(MAX_LEN + 1, 8'h5A, 1, 8'h00, 1'b0);
    checkOutput(0);
    applyStimulus(MAX_LEN, 8'h11, 1, 8'h00, 1'b0);
    checkOutput(0);

    $display("[TB] consecutive failures raise the alarm");
    for (int f = 0; f < 3; f++) begin
      applyStimulus(1, 8'h00, 0, 8'h30, 1'b0);
      checkOutput(0);
    end
    applyStimulus(4, 8'hA3, 1, 8'h00, 1'b0);
    checkOutput(0);
    clearAlarm();

    $display("[TB] consumer back-pressure");
    applyStimulus(5, 8'h3C, 1, 8'h00, 1'b0);
    checkOutput(5);

    $display("[TB] nonzero upper CRC bits and clear during a bad check");
    applyStimulus(3, 8'h77, 2, 8'h00, 1'b0);
    checkOutput(1);
    applyStimulus(2, 8'h01, 0, 8'h00, 1'b1);
    checkOutput(0);
    applyStimulus(1, 8'h00, 0, 8'h30, 1'b0);
    checkOutput(0);
    applyStimulus(1, 8'h00, 0, 8'h30, 1'b0);
    checkOutput(0);

    $display("[TB] reset in the middle of a payload");
    sendBeat(8'h12, 1'b0);
    sendBeat(8'h34, 1'b0);
    sendBeat(8'h56, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    checkAllZero("midframe_reset");
    failCnt    = 0;
    alarmExp   = 1'b0;
    goodFrames = 16'd0;
    badFrames  = 16'd0;
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] frames after reset, two good and one bad");
    applyStimulus(1, 8'h00, 0, 8'h31, 1'b0);
    checkOutput(0);
    applyStimulus(0, 8'h00, 0, 8'h37, 1'b0);
    checkOutput(0);
    applyStimulus(0, 8'h00, 0, 8'h35, 1'b0);
    checkOutput(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
